// File: rtl/decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl
//   Pipeline control for the ID/EX decode register of the interpolation ASIP.
//   It injects a one-cycle bubble on load-use hazards and serialises
//   multi-cycle vector operations through a busy counter. Taken branches flush
//   the front end. It also keeps a saturating count of PC-hold cycles.
//
// Parameters
//   VEC_LAT      cycles the vector unit is occupied per issued vector op (>=1)
//   CNT_W        width of the stall performance counter
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   id_valid     in   decode stage holds a valid instruction
//   id_rs1/2     in   decode source registers
//   id_use_rs1/2 in   instruction reads rs1 / rs2
//   id_is_vec    in   instruction is a vector op
//   ex_rd        in   destination register of the instruction in EX
//   ex_load      in   EX instruction is a memory load
//   ex_reg_write in   EX instruction writes the register file
//   branch_taken in   branch resolved taken in EX this cycle
//   pc_hold      out  freeze PC
//   ifid_hold    out  freeze IF/ID register
//   ifid_flush   out  clear IF/ID register
//   idex_bubble  out  load NOP controls into ID/EX register
//   vec_busy     out  vector unit occupied
//   stall_cnt    out  saturating count of pc_hold cycles
// -----------------------------------------------------------------------------
module decode_hazard_ctrl #(
    parameter int VEC_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_vec,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_reg_write,
    input  logic             branch_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             vec_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int VC_W = $clog2(VEC_LAT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        VBUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [VC_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;
    logic vs;
    logic issue_vec;
    logic hold;

    always_comb begin
        lu = id_valid && ex_load && ex_reg_write && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
        vs = id_valid && id_is_vec && (vec_cnt_q != '0);
        // A branch cancels the decode instruction, so it must not start the unit.
        issue_vec = id_valid && id_is_vec && !branch_taken && !lu &&
                    (vec_cnt_q == '0);
        hold = !branch_taken && (lu || vs);
    end

    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        case (state_q)
            IDLE: begin
                // With VEC_LAT==1 the unit is free again next cycle: no busy state.
                if (issue_vec && (VEC_LAT > 1)) begin
                    state_d   = VBUSY;
                    vec_cnt_d = VC_W'(VEC_LAT - 1);
                end
            end
            VBUSY: begin
                // Branches do not abort an issued vector op.
                vec_cnt_d = vec_cnt_q - 1'b1;
                if (vec_cnt_q == VC_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                vec_cnt_d = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            vec_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are forced low while reset is held, even though
    // the hazard terms themselves come straight from the inputs.
    assign pc_hold     = rst & hold;
    assign ifid_hold   = rst & hold;
    assign ifid_flush  = rst & branch_taken;
    assign idex_bubble = rst & (branch_taken | lu | vs);
    assign vec_busy    = rst & (state_q == VBUSY);
    assign stall_cnt   = stall_cnt_q;

endmodule
